nrisc_mux_arb: RTL and testbench

- Parametrised successor to the NRISC 16:1 datapath mux: N channels of TAM bits, one registered output stage with valid/ready handshake on every channel.
- Two modes. MODE 0 uses an externally driven select. MODE 1 uses round-robin arbitration among valid channels.
- Sits between multiple producers (ULA results, load data, immediate paths) and a single consumer such as register-file writeback or a shared bus.

---
 rtl/nrisc_mux_pkg.sv | 26 ++
 rtl/nrisc_rr_arbiter.sv | 28 ++
 rtl/nrisc_mux_arb.sv | 134 +++++++++++++
 tb/tb_nrisc_mux_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_mux_pkg.sv
// nrisc_mux_pkg: shared constants and helpers for the NRISC channel mux.
// Optional burst lock is enabled with the NRISC_MUX_LOCK_EN macro.
package nrisc_mux_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  // Widest flattened bus and channel word the helper can slice.
  localparam int MUX_BUS_MAX = 2048;
  localparam int MUX_TAM_MAX = 64;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MUX_TAM_MAX-1:0] chan_word(
    input logic [MUX_BUS_MAX-1:0] bus,
    input int                     k,
    input int                     tam
  );
    logic [MUX_BUS_MAX-1:0] sh;
    sh = bus >> (k * tam);
    return sh[MUX_TAM_MAX-1:0];
  endfunction

endpackage

// File: rtl/nrisc_rr_arbiter.sv
// nrisc_rr_arbiter: combinational round-robin pick, searching from ptr+1.
// Pointer state is owned by the parent (nrisc_mux_arb).
module nrisc_rr_arbiter #(
  parameter int N    = 16,
  parameter int SELW = 4
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt,
  output logic            gnt_vld
);

  // First requester after ptr wins, wrapping modulo N.
  always_comb begin
    logic [SELW-1:0] idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N; i++) begin
      idx = SELW'((int'(ptr) + i) % N);
      if (!gnt_vld && req[idx]) begin
        gnt     = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nrisc_mux_arb.sv
// nrisc_mux_arb: N-channel registered mux, external select or round-robin.
// Define NRISC_MUX_LOCK_EN to add burst lock via MUX_last_in/MUX_last_out.
module nrisc_mux_arb
  import nrisc_mux_pkg::*;
#(
  parameter int TAM  = 16,
  parameter int N    = 16,
  parameter int MODE = MUX_MODE_SEL,
  localparam int SELW = sel_width(N)
) (
  input  logic            MUX_clk,
  input  logic            MUX_rst_n,
  input  logic [N*TAM-1:0] MUX_in,
  input  logic [N-1:0]    MUX_valid_in,
  output logic [N-1:0]    MUX_ready_out,
  input  logic [SELW-1:0] MUX_sel,
  output logic [TAM-1:0]  MUX_Out,
  output logic            MUX_valid_out,
  input  logic            MUX_ready_in,
`ifdef NRISC_MUX_LOCK_EN
  input  logic [N-1:0]    MUX_last_in,
  output logic            MUX_last_out,
`endif
  output logic [SELW-1:0] MUX_grant
);

  logic [SELW-1:0]        base;
  logic                   base_vld;
  logic [SELW-1:0]        cand;
  logic                   cand_vld;
  logic                   load;
  logic                   xfer;
  logic [MUX_TAM_MAX-1:0] wide;
  logic [TAM-1:0]         word;

  if (MODE == MUX_MODE_RR) begin : g_rr
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] gnt;
    logic            gvld;
    logic            unused_sel;

    assign unused_sel = ^MUX_sel;

    nrisc_rr_arbiter #(
      .N    (N),
      .SELW (SELW)
    ) u_arb (
      .req     (MUX_valid_in),
      .ptr     (ptr),
      .gnt     (gnt),
      .gnt_vld (gvld)
    );

    // Pointer follows the last granted channel; reset gives channel 0 priority.
    always_ff @(posedge MUX_clk) begin
      if (!MUX_rst_n) begin
        ptr <= SELW'(N - 1);
      end else if (xfer) begin
        ptr <= cand;
      end
    end

    assign base     = gnt;
    assign base_vld = gvld;
  end else begin : g_sel
    assign base     = MUX_sel;
    assign base_vld = (int'(MUX_sel) < N);
  end

`ifdef NRISC_MUX_LOCK_EN
  logic            lock;
  logic [SELW-1:0] lock_ch;

  // Lock holds the channel between a non-last and a last transfer.
  always_ff @(posedge MUX_clk) begin
    if (!MUX_rst_n) begin
      lock    <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      lock    <= ~MUX_last_in[cand];
      lock_ch <= cand;
    end
  end
`endif

  // Candidate channel: mode choice, overridden by an active lock.
  always_comb begin
    cand     = base;
    cand_vld = base_vld;
`ifdef NRISC_MUX_LOCK_EN
    if (lock) begin
      cand     = lock_ch;
      cand_vld = 1'b1;
    end
`endif
  end

  assign load = ~MUX_valid_out | MUX_ready_in;
  assign xfer = MUX_rst_n & load & cand_vld & MUX_valid_in[cand];
  assign wide = chan_word(MUX_BUS_MAX'(MUX_in), int'(cand), TAM);
  assign word = wide[TAM-1:0];

  assign MUX_ready_out =
    xfer ? ({{(N-1){1'b0}}, 1'b1} << cand) : '0;

  // Output register: load on transfer, empty on idle load, hold on stall.
  always_ff @(posedge MUX_clk) begin
    if (!MUX_rst_n) begin
      MUX_Out       <= '0;
      MUX_valid_out <= 1'b0;
      MUX_grant     <= '0;
    end else if (load) begin
      if (xfer) begin
        MUX_Out       <= word;
        MUX_grant     <= cand;
        MUX_valid_out <= 1'b1;
      end else begin
        MUX_valid_out <= 1'b0;
      end
    end
  end

`ifdef NRISC_MUX_LOCK_EN
  // End-of-burst flag travels with the data word.
  always_ff @(posedge MUX_clk) begin
    if (!MUX_rst_n) begin
      MUX_last_out <= 1'b0;
    end else if (xfer) begin
      MUX_last_out <= MUX_last_in[cand];
    end
  end
`endif

endmodule

// File: tb/tb_nrisc_mux_arb.sv
// tb_nrisc_mux_arb: select-mode and round-robin instances with a scoreboard.
// Lock sequence is exercised when NRISC_MUX_LOCK_EN is defined.
module tb_nrisc_mux_arb;

  localparam int N   = 16;
  localparam int TAM = 16;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  gnt;
    logic        last;
  } exp_t;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] vin;
    logic        rdy;
    logic [15:0] exp_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [15:0]      din_s [N];
  logic [15:0]      din_r [N];
  logic [N*TAM-1:0] in_s, in_r;
  logic [N-1:0]     vin_s, vin_r, rdyo_s, rdyo_r;
  logic [3:0]       sel_s, sel_r, gnt_s, gnt_r;
  logic [15:0]      out_s, out_r;
  logic             vout_s, vout_r, rdyi_s, rdyi_r;
`ifdef NRISC_MUX_LOCK_EN
  logic [N-1:0]     lin_s, lin_r;
  logic             lout_s, lout_r;
`endif

  always_comb begin
    in_s = '0;
    in_r = '0;
    for (int k = 0; k < N; k++) begin
      in_s[k*TAM +: TAM] = din_s[k];
      in_r[k*TAM +: TAM] = din_r[k];
    end
  end

  nrisc_mux_arb #(.TAM(TAM), .N(N), .MODE(0)) u_sel (
    .MUX_clk       (clk),
    .MUX_rst_n     (rst_n),
    .MUX_in        (in_s),
    .MUX_valid_in  (vin_s),
    .MUX_ready_out (rdyo_s),
    .MUX_sel       (sel_s),
    .MUX_Out       (out_s),
    .MUX_valid_out (vout_s),
    .MUX_ready_in  (rdyi_s),
`ifdef NRISC_MUX_LOCK_EN
    .MUX_last_in   (lin_s),
    .MUX_last_out  (lout_s),
`endif
    .MUX_grant     (gnt_s)
  );

  nrisc_mux_arb #(.TAM(TAM), .N(N), .MODE(1)) u_rr (
    .MUX_clk       (clk),
    .MUX_rst_n     (rst_n),
    .MUX_in        (in_r),
    .MUX_valid_in  (vin_r),
    .MUX_ready_out (rdyo_r),
    .MUX_sel       (sel_r),
    .MUX_Out       (out_r),
    .MUX_valid_out (vout_r),
    .MUX_ready_in  (rdyi_r),
`ifdef NRISC_MUX_LOCK_EN
    .MUX_last_in   (lin_r),
    .MUX_last_out  (lout_r),
`endif
    .MUX_grant     (gnt_r)
  );

  exp_t q_s[$];
  exp_t q_r[$];
  int   total  = 0;
  int   passed = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Consumer side: a word leaves at each edge with valid & ready.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (vout_s && rdyi_s) begin
        if (q_s.size() == 0) chk("sel_extra_word", 32'd1, 32'd0);
        else begin
          e = q_s.pop_front();
          chk("sel_data", 32'(out_s), 32'(e.data));
          chk("sel_grant", 32'(gnt_s), 32'(e.gnt));
        end
      end
      if (vout_r && rdyi_r) begin
        if (q_r.size() == 0) chk("rr_extra_word", 32'd1, 32'd0);
        else begin
          e = q_r.pop_front();
          chk("rr_data", 32'(out_r), 32'(e.data));
          chk("rr_grant", 32'(gnt_r), 32'(e.gnt));
`ifdef NRISC_MUX_LOCK_EN
          chk("rr_last", 32'(lout_r), 32'(e.last));
`endif
        end
      end
    end
  end

  vec_t        tv [9];
  logic [15:0] sp_mask [10];
  int          sp_gnt  [10];

  initial begin
    rst_n  = 1'b0;
    sel_s  = 4'd0;
    sel_r  = 4'd0;
    rdyi_s = 1'b1;
    rdyi_r = 1'b1;
    vin_s  = '1;
    vin_r  = '1;
`ifdef NRISC_MUX_LOCK_EN
    lin_s  = '1;
    lin_r  = '1;
`endif
    for (int k = 0; k < N; k++) begin
      din_s[k] = 16'hC000 + 16'(k) * 16'h0101;
      din_r[k] = 16'(k);
    end
    din_s[5] = 16'hA5A5;

    tv[0] = '{4'd5,  16'h0020, 1'b1, 16'h0020};
    tv[1] = '{4'd5,  16'h0000, 1'b1, 16'h0000};
    tv[2] = '{4'd0,  16'hFFFF, 1'b1, 16'h0001};
    tv[3] = '{4'd15, 16'h8000, 1'b1, 16'h8000};
    tv[4] = '{4'd3,  16'hFFF7, 1'b1, 16'h0000};
    tv[5] = '{4'd9,  16'h0200, 1'b1, 16'h0200};
    tv[6] = '{4'd9,  16'h0200, 1'b0, 16'h0000};
    tv[7] = '{4'd9,  16'h0200, 1'b1, 16'h0200};
    tv[8] = '{4'd1,  16'hFFFF, 1'b0, 16'h0000};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vin_s = '0;
    vin_r = '0;
    @(negedge clk);
    chk("rst_vout_s", 32'(vout_s), 32'd0);
    chk("rst_out_s", 32'(out_s), 32'd0);
    chk("rst_gnt_s", 32'(gnt_s), 32'd0);
    chk("rst_rdy_s", 32'(rdyo_s), 32'd0);
    chk("rst_vout_r", 32'(vout_r), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    chk("rst_gnt_r", 32'(gnt_r), 32'd0);
    chk("rst_rdy_r", 32'(rdyo_r), 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      sel_s  = tv[i].sel;
      vin_s  = tv[i].vin;
      rdyi_s = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("sel_vec%0d_ready", i), 32'(rdyo_s),
          32'(tv[i].exp_rdy));
      if (tv[i].exp_rdy != 16'd0)
        q_s.push_back('{din_s[tv[i].sel], tv[i].sel, 1'b1});
    end

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      rdyi_s = 1'b0;
      @(negedge clk);
      chk("bp_ready", 32'(rdyo_s), 32'd0);
      chk("bp_hold", 32'(out_s), 32'(din_s[9]));
      chk("bp_vout", 32'(vout_s), 32'd1);
    end
    @(posedge clk);
    #1;
    rdyi_s = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(rdyo_s), 32'h0002);
    q_s.push_back('{din_s[1], 4'd1, 1'b1});
    @(posedge clk);
    #1;
    vin_s = '0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      vin_r = '1;
      @(negedge clk);
      chk($sformatf("rr_fair%0d_ready", i), 32'(rdyo_r),
          32'(1) << (i % 16));
      q_r.push_back('{16'(i % 16), 4'(i % 16), 1'b1});
    end
    @(posedge clk);
    #1;
    vin_r = '0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < N; k++) din_r[k] = 16'h5000 + 16'(k);
    sp_mask[0] = 16'h4000; sp_gnt[0] = 14;
    sp_mask[1] = 16'h4008; sp_gnt[1] = 3;
    sp_mask[2] = 16'h4008; sp_gnt[2] = 14;
    sp_mask[3] = 16'h4008; sp_gnt[3] = 3;
    sp_mask[4] = 16'h0040; sp_gnt[4] = 6;
    sp_mask[5] = 16'h0040; sp_gnt[5] = 6;
    sp_mask[6] = 16'h0040; sp_gnt[6] = 6;
    sp_mask[7] = 16'h0000; sp_gnt[7] = -1;
    sp_mask[8] = 16'h00A0; sp_gnt[8] = 7;
    sp_mask[9] = 16'h0000; sp_gnt[9] = -1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      vin_r = sp_mask[i];
      @(negedge clk);
      if (sp_gnt[i] >= 0) begin
        chk($sformatf("rr_sparse%0d_ready", i), 32'(rdyo_r),
            32'(1) << sp_gnt[i]);
        q_r.push_back('{din_r[sp_gnt[i]], 4'(sp_gnt[i]), 1'b1});
      end else begin
        chk($sformatf("rr_sparse%0d_ready", i), 32'(rdyo_r), 32'd0);
      end
    end
    repeat (2) @(posedge clk);

`ifdef NRISC_MUX_LOCK_EN
    for (int i = 0; i < 4; i++) begin
      logic [3:0] g;
      logic       f;
      g = (i < 3) ? 4'd2 : 4'd7;
      f = (i == 2) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      vin_r = 16'h0084;
      lin_r = '1;
      lin_r[2] = f;
      @(negedge clk);
      chk($sformatf("lock%0d_ready", i), 32'(rdyo_r), 32'(1) << g);
      q_r.push_back('{din_r[g], g, (i < 3) ? f : 1'b1});
    end
    @(posedge clk);
    #1;
    vin_r = '0;
    repeat (2) @(posedge clk);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sel_queue_empty", 32'(q_s.size()), 32'd0);
    chk("rr_queue_empty", 32'(q_r.size()), 32'd0);
    chk("end_vout_s", 32'(vout_s), 32'd0);
    chk("end_vout_r", 32'(vout_r), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
